// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width, opcode encodings,
// shifter modes and a bit-reverse helper.
package alu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [4:0] OP_NOP   = 5'h00;
   localparam logic [4:0] OP_ADD   = 5'h01;
   localparam logic [4:0] OP_SUB   = 5'h02;
   localparam logic [4:0] OP_MUL   = 5'h03;
   localparam logic [4:0] OP_AND   = 5'h04;
   localparam logic [4:0] OP_OR    = 5'h05;
   localparam logic [4:0] OP_XOR   = 5'h06;
   localparam logic [4:0] OP_SLL   = 5'h07;
   localparam logic [4:0] OP_SRA   = 5'h08;
   localparam logic [4:0] OP_SRL   = 5'h09;
   localparam logic [4:0] OP_SLT   = 5'h0A;
   localparam logic [4:0] OP_SLTU  = 5'h0B;
   localparam logic [4:0] OP_BEQ   = 5'h0C;
   localparam logic [4:0] OP_BNE   = 5'h0D;
   localparam logic [4:0] OP_BLT   = 5'h0E;
   localparam logic [4:0] OP_BGE   = 5'h0F;
   localparam logic [4:0] OP_BLTU  = 5'h10;
   localparam logic [4:0] OP_BGEU  = 5'h11;
   localparam logic [4:0] OP_SLLI  = 5'h12;
   localparam logic [4:0] OP_SRLI  = 5'h13;
   localparam logic [4:0] OP_SRAI  = 5'h14;
   localparam logic [4:0] OP_LUI   = 5'h15;
   localparam logic [4:0] OP_AUIPC = 5'h16;

   typedef enum logic [1:0] {
      SH_LL = 2'd0,
      SH_RL = 2'd1,
      SH_RA = 2'd2
   } shift_mode_e;

   function automatic logic [XLEN-1:0] bit_rev(
      input logic [XLEN-1:0] x
   );
      logic [XLEN-1:0] r;
      for (int i = 0; i < int'(XLEN); i++) begin
         r[i] = x[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/select inputs and registered result/flag
// of the execute-stage ALU.
interface alu_if;
   import alu_pkg::*;

   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [4:0]      S;
   logic [XLEN-1:0] Q;
   logic            CMP;

   modport master (
      output A, B, S,
      input  Q, CMP
   );

   modport slave (
      input  A, B, S,
      output Q, CMP
   );

endinterface

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: left, logical
// right and arithmetic right by a 5-bit amount.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [4:0]      shamt_i,
   input  shift_mode_e     mode_i,
   output logic [XLEN-1:0] y_o
);

   logic            left;
   logic            fill;
   logic [XLEN-1:0] st [6];

   // left shifts reuse the right-shift network on reversed data
   assign left  = (mode_i == SH_LL);
   assign fill  = (mode_i == SH_RA) & a_i[XLEN-1];
   assign st[0] = left ? bit_rev(a_i) : a_i;

   for (genvar i = 0; i < 5; i++) begin : g_stage
      localparam int N = 1 << i;
      assign st[i+1] = shamt_i[i]
         ? {{N{fill}}, st[i][XLEN-1:N]}
         : st[i];
   end

   assign y_o = left ? bit_rev(st[5]) : st[5];

endmodule

// File: rtl/alu.sv
// RV32I+MUL execute-stage ALU with registered
// result and compare/branch flag.
module alu
   import alu_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   alu_if.slave  io
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic [XLEN-1:0] prod;
   logic [XLEN-1:0] shres;
   logic            lt_s;
   logic            lt_u;
   logic            eq;
   shift_mode_e     shmode;

   logic [XLEN-1:0] q_d, q_q;
   logic            cmp_d, cmp_q;

   assign sum  = io.A + io.B;
   assign diff = io.A - io.B;
   assign prod = io.A * io.B;
   assign lt_s = $signed(io.A) < $signed(io.B);
   assign lt_u = io.A < io.B;
   assign eq   = io.A == io.B;

   always_comb begin
      shmode = SH_LL;
      unique case (io.S)
         OP_SRA, OP_SRAI: shmode = SH_RA;
         OP_SRL, OP_SRLI: shmode = SH_RL;
         default:         shmode = SH_LL;
      endcase
   end

   alu_shifter u_shifter (
      .a_i     (io.A),
      .shamt_i (io.B[4:0]),
      .mode_i  (shmode),
      .y_o     (shres)
   );

   always_comb begin
      q_d   = '0;
      cmp_d = 1'b0;
      unique case (io.S)
         OP_ADD:   q_d = sum;
         OP_SUB:   q_d = diff;
         OP_MUL:   q_d = prod;
         OP_AND:   q_d = io.A & io.B;
         OP_OR:    q_d = io.A | io.B;
         OP_XOR:   q_d = io.A ^ io.B;
         OP_SLL,
         OP_SLLI,
         OP_SRA,
         OP_SRAI,
         OP_SRL,
         OP_SRLI:  q_d = shres;
         OP_SLT: begin
            q_d   = {{(XLEN-1){1'b0}}, lt_s};
            cmp_d = lt_s;
         end
         OP_SLTU: begin
            q_d   = {{(XLEN-1){1'b0}}, lt_u};
            cmp_d = lt_u;
         end
         OP_BEQ:   cmp_d = eq;
         OP_BNE:   cmp_d = ~eq;
         OP_BLT:   cmp_d = lt_s;
         OP_BGE:   cmp_d = ~lt_s;
         OP_BLTU:  cmp_d = lt_u;
         OP_BGEU:  cmp_d = ~lt_u;
         OP_LUI:   q_d = io.B;
         OP_AUIPC: q_d = sum;
         default: begin
            q_d   = '0;
            cmp_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q   <= '0;
         cmp_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         cmp_q <= cmp_d;
      end
   end

   assign io.Q   = q_q;
   assign io.CMP = cmp_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the execute-stage ALU.
`timescale 1ns/1ps
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      logic [4:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        c;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   alu_if io ();

   alu u_dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(
      input logic [4:0]  s,
      input logic [31:0] a,
      input logic [31:0] b
   );
      @(negedge clk);
      io.S = s;
      io.A = a;
      io.B = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst  = 1'b1;
      io.S = OP_ADD;
      io.A = 32'd5;
      io.B = 32'd7;
      @(posedge clk);
      #1;
      checks++;
      if (io.Q !== 32'h0) begin
         failures++;
         $display("FAIL reset_q got=%h exp=%h", io.Q, 32'h0);
      end
      checks++;
      if (io.CMP !== 1'b0) begin
         failures++;
         $display("FAIL reset_cmp got=%b exp=0", io.CMP);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (io.Q !== 32'd12) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", io.Q, 32'd12);
      end
      // reset asserted with an operation pending discards it
      @(negedge clk);
      rst  = 1'b1;
      io.S = OP_SUB;
      io.A = 32'd9;
      io.B = 32'd2;
      @(posedge clk);
      #1;
      checks++;
      if (io.Q !== 32'h0) begin
         failures++;
         $display("FAIL reset_discard got=%h exp=%h", io.Q, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_table(input string name, input vec_t v[$]);
      foreach (v[i]) begin
         drive(v[i].s, v[i].a, v[i].b);
         checks++;
         if (io.Q !== v[i].q) begin
            failures++;
            $display("FAIL %s[%0d]_q s=%h got=%h exp=%h",
                     name, i, v[i].s, io.Q, v[i].q);
         end
         checks++;
         if (io.CMP !== v[i].c) begin
            failures++;
            $display("FAIL %s[%0d]_cmp s=%h got=%b exp=%b",
                     name, i, v[i].s, io.CMP, v[i].c);
         end
      end
   endtask

   task automatic test_arith;
      vec_t v[$];
      v.push_back('{OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0});
      v.push_back('{OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 1'b0});
      v.push_back('{OP_SUB, 32'hFFFFFFFF, 32'h1,
                    32'hFFFFFFFE, 1'b0});
      v.push_back('{OP_SUB, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'h0, 1'b0});
      v.push_back('{OP_MUL, 32'd3, 32'hFFFFFFFE,
                    32'hFFFFFFFA, 1'b0});
      v.push_back('{OP_MUL, 32'h00010001, 32'h00010001,
                    32'h00020001, 1'b0});
      v.push_back('{OP_NOP, 32'hFFFFFFFF, 32'h5, 32'h0, 1'b0});
      v.push_back('{5'h1F, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'h0, 1'b0});
      v.push_back('{5'h17, 32'h12345678, 32'h1, 32'h0, 1'b0});
      v.push_back('{OP_LUI, 32'hDEAD0000, 32'hABCDE000,
                    32'hABCDE000, 1'b0});
      v.push_back('{OP_AUIPC, 32'h00001000, 32'h00045000,
                    32'h00046000, 1'b0});
      run_table("arith", v);
   endtask

   task automatic test_logic;
      vec_t v[$];
      v.push_back('{OP_AND, 32'hF0F0F0F0, 32'h0FF0F00F,
                    32'h00F0F000, 1'b0});
      v.push_back('{OP_OR, 32'hF0F0F0F0, 32'h0FF0F00F,
                    32'hFFF0F0FF, 1'b0});
      v.push_back('{OP_XOR, 32'hF0F0F0F0, 32'h0FF0F00F,
                    32'hFF0000FF, 1'b0});
      run_table("logic", v);
   endtask

   task automatic test_shift;
      vec_t v[$];
      v.push_back('{OP_SLL, 32'hF0F0F0F7, 32'd2,
                    32'hC3C3C3DC, 1'b0});
      v.push_back('{OP_SRA, 32'hF0F0F0F7, 32'd3,
                    32'hFE1E1E1E, 1'b0});
      v.push_back('{OP_SRL, 32'hF0F0F0F7, 32'd5,
                    32'h07878787, 1'b0});
      v.push_back('{OP_SRA, 32'h00F0F0F7, 32'hFFFFFFFC,
                    32'h0, 1'b0});
      v.push_back('{OP_SLLI, 32'h00000001, 32'h0000003F,
                    32'h80000000, 1'b0});
      v.push_back('{OP_SRLI, 32'h80000000, 32'd31,
                    32'h00000001, 1'b0});
      v.push_back('{OP_SRAI, 32'h80000000, 32'd31,
                    32'hFFFFFFFF, 1'b0});
      v.push_back('{OP_SLL, 32'hA5A5A5A5, 32'hFFFFFFE0,
                    32'hA5A5A5A5, 1'b0});
      v.push_back('{OP_SRA, 32'h9ABCDEF0, 32'd0,
                    32'h9ABCDEF0, 1'b0});
      v.push_back('{OP_SRL, 32'h9ABCDEF0, 32'd0,
                    32'h9ABCDEF0, 1'b0});
      v.push_back('{OP_SRA, 32'h7FFFFFFF, 32'd31,
                    32'h0, 1'b0});
      run_table("shift", v);
   endtask

   task automatic test_slt;
      vec_t v[$];
      v.push_back('{OP_SLT, 32'(-35), 32'(-75), 32'h0, 1'b0});
      v.push_back('{OP_SLT, 32'(-65510), 32'(-26), 32'h1, 1'b1});
      v.push_back('{OP_SLTU, 32'd61, 32'hFFFFFFBF, 32'h1, 1'b1});
      v.push_back('{OP_SLTU, 32'd928, 32'd741, 32'h0, 1'b0});
      v.push_back('{OP_SLT, 32'h80000000, 32'h7FFFFFFF,
                    32'h1, 1'b1});
      v.push_back('{OP_SLTU, 32'h80000000, 32'h7FFFFFFF,
                    32'h0, 1'b0});
      run_table("slt", v);
   endtask

   task automatic test_branch;
      vec_t v[$];
      v.push_back('{OP_BEQ, 32'(-27650), 32'(-27650), 32'h0, 1'b1});
      v.push_back('{OP_BEQ, 32'd1, 32'd2, 32'h0, 1'b0});
      v.push_back('{OP_BNE, 32'd742, 32'd742, 32'h0, 1'b0});
      v.push_back('{OP_BNE, 32'd742, 32'd743, 32'h0, 1'b1});
      v.push_back('{OP_BLT, 32'(-48), 32'd2795, 32'h0, 1'b1});
      v.push_back('{OP_BGE, 32'(-472543), 32'(-27), 32'h0, 1'b0});
      v.push_back('{OP_BGE, 32'd99, 32'd99, 32'h0, 1'b1});
      v.push_back('{OP_BGEU, 32'd99, 32'd99, 32'h0, 1'b1});
      v.push_back('{OP_BLT, 32'd99, 32'd99, 32'h0, 1'b0});
      v.push_back('{OP_BLTU, 32'd99, 32'd99, 32'h0, 1'b0});
      v.push_back('{OP_BLTU, 32'd8, 32'd5298, 32'h0, 1'b1});
      v.push_back('{OP_BGEU, 32'd238, 32'd65298, 32'h0, 1'b0});
      v.push_back('{OP_BLT, 32'h80000000, 32'h7FFFFFFF,
                    32'h0, 1'b1});
      v.push_back('{OP_BLTU, 32'h80000000, 32'h7FFFFFFF,
                    32'h0, 1'b0});
      run_table("branch", v);
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      io.S = OP_ADD;
      io.A = 32'd100;
      io.B = 32'd23;
      @(posedge clk);
      #1;
      io.S = OP_BEQ;
      io.A = 32'd4;
      io.B = 32'd4;
      checks++;
      if (io.Q !== 32'd123 || io.CMP !== 1'b0) begin
         failures++;
         $display("FAIL b2b_first got=%h/%b exp=%h/0",
                  io.Q, io.CMP, 32'd123);
      end
      @(posedge clk);
      #1;
      io.S = OP_XOR;
      io.A = 32'hFFFF0000;
      io.B = 32'h0F0F0F0F;
      checks++;
      if (io.Q !== 32'h0 || io.CMP !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second got=%h/%b exp=0/1",
                  io.Q, io.CMP);
      end
      @(posedge clk);
      #1;
      checks++;
      if (io.Q !== 32'hF0F00F0F || io.CMP !== 1'b0) begin
         failures++;
         $display("FAIL b2b_third got=%h/%b exp=%h/0",
                  io.Q, io.CMP, 32'hF0F00F0F);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      io.S     = OP_NOP;
      io.A     = '0;
      io.B     = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_arith();
      test_logic();
      test_shift();
      test_slt();
      test_branch();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit integer ALU for the RISC-V (RV32I + MUL) execute stage.
- Takes two operands A/B and a 5-bit operation select S.
- Produces a 32-bit result Q and a 1-bit compare/branch flag CMP.
- Outputs are registered: one clock cycle of latency, synchronous active-high reset.

Parameters:
- None. Data width is fixed at 32; select width is fixed at 5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- A  in  32  operand A (rs1 or PC).
- B  in  32  operand B (rs2 or immediate).
- S  in  5  operation select (codes below).
- Q  out  32  registered result.
- CMP  out  1  registered compare/branch-taken flag.

Behaviour:
- Reset: on a rising clk edge with rst=1, Q<=0 and CMP<=0. Reset has priority over any operation; an operation in flight is discarded.
- Latency: Q/CMP reflect the A, B, S sampled at the previous rising edge. No handshake; a new operation is accepted every cycle.
- Arithmetic wraps modulo 2^32. No overflow or carry flags.
- Shift amount is always B[4:0]; B[31:5] is ignored.
- Operation codes (Q result; CMP):
  - 0x01 ADD: A+B; CMP=0.
  - 0x02 SUB: A-B; CMP=0.
  - 0x03 MUL: low 32 bits of A*B; CMP=0.
  - 0x04 AND: A&B; CMP=0.
  - 0x05 OR: A|B; CMP=0.
  - 0x06 XOR: A^B; CMP=0.
  - 0x07 SLL / 0x12 SLLI: A<<B[4:0]; CMP=0.
  - 0x08 SRA / 0x14 SRAI: signed A>>>B[4:0], sign-filled; CMP=0.
  - 0x09 SRL / 0x13 SRLI: A>>B[4:0], zero-filled; CMP=0.
  - 0x0A SLT: Q={31'b0,lt_s}, CMP=lt_s, where lt_s = signed A<B.
  - 0x0B SLTU: Q={31'b0,lt_u}, CMP=lt_u, where lt_u = unsigned A<B.
  - 0x0C BEQ: CMP=(A==B); Q=0.
  - 0x0D BNE: CMP=(A!=B); Q=0.
  - 0x0E BLT: CMP=lt_s; Q=0.
  - 0x0F BGE: CMP=!lt_s; Q=0.
  - 0x10 BLTU: CMP=lt_u; Q=0.
  - 0x11 BGEU: CMP=!lt_u; Q=0.
  - 0x15 LUI: Q=B (decoder supplies the already-shifted upper immediate); CMP=0.
  - 0x16 AUIPC: Q=A+B (A=PC); CMP=0.
- Unimplemented codes 0x00 and 0x17–0x1F: Q=0, CMP=0.
- Boundaries:
  - Shift by 0 passes A unchanged.
  - SRA of negative A by 31 gives 0xFFFFFFFF.
  - Signed compare 0x80000000 < 0x7FFFFFFF is true; the unsigned compare is false.
  - Equal operands: BGE/BGEU true, BLT/BLTU false.

Decomposition:
- Shared package alu_pkg: 5-bit opcode constants for all 22 codes above and the width constant 32.
- One sub-module, alu_shifter: a combinational 32-bit barrel shifter with left/logical-right/arithmetic-right modes and a 5-bit amount.
- The top module holds the opcode decode, adder/subtractor, multiplier, comparators and the output registers.

Test Plan:
- Reset: hold rst=1 with S=ADD, A=5, B=7 -> Q=0, CMP=0. Release rst -> next cycle Q=12.
- Arithmetic: ADD with A=0xFFFFFFFF, B=1 -> Q=0. ADD -1+-1 -> 0xFFFFFFFE. SUB -1-1 -> 0xFFFFFFFE. SUB -1-(-1) -> 0. MUL 3*-2 -> 0xFFFFFFFA. S=0x00 with A=-1 -> Q=0.
- Logic: A=0xF0F0F0F0, B=0x0FF0F00F -> AND 0x00F0F000, OR 0xFFF0F0FF, XOR 0xFF0000FF.
- Shifts: A=0xF0F0F0F7 -> SLL by 2 gives 0xC3C3C3DC; SRA by 3 gives 0xFE1E1E1E; SRL by 5 gives 0x07878787. SRA with A=0x00F0F0F7, B=0xFFFFFFFC (amount 28) -> 0x00000000.
- Set-less-than: SLT -35 vs -75 -> Q=0, CMP=0. SLT -65510 vs -26 -> Q=1, CMP=1. SLTU 61 vs 0xFFFFFFBF -> Q=1, CMP=1. SLTU 928 vs 741 -> Q=0.
- Branches:
  - BEQ -27650,-27650 -> CMP=1.
  - BNE 742,742 -> CMP=0.
  - BLT -48,2795 -> CMP=1.
  - BGE -472543,-27 -> CMP=0.
  - BGE equal operands -> CMP=1.
  - BLTU 8,5298 -> CMP=1.
  - BGEU 238,65298 -> CMP=0.
  - Q=0 in all branch cases.
